// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported, one-cycle-read-latency memory between an
// instruction-fetch port and a load/store port. One transaction is in flight
// at a time and walks IDLE -> ISSUE -> RESP, so the handshake-to-response
// latency is 2 cycles and the throughput is one access every 3 cycles.
// The LSU wins collisions until fetch has been passed over STARVE_MAX times
// in a row. After that, fetch wins the next collision.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req_valid/ready/addr     fetch request (word read)
//   if_flush                    branch redirect; drops the pending fetch reply
//   if_rsp_valid/data           fetch reply (one-cycle pulse)
//   ls_req_valid/ready/we/addr/ LSU request (load or store)
//     byte_en/wdata
//   ls_rsp_valid/data           LSU reply; data is 0 for store completions
//   mem_addr/r_enable/w_enable/ memory side; mem_r_data arrives one cycle
//     byte_en/w_data/r_data     after the mem_r_enable cycle
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    input  logic        if_flush,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic        ls_req_we,
    input  logic [31:0] ls_req_addr,
    input  logic [3:0]  ls_req_byte_en,
    input  logic [31:0] ls_req_wdata,
    output logic        ls_rsp_valid,
    output logic [31:0] ls_rsp_data,
    output logic [31:0] mem_addr,
    output logic        mem_r_enable,
    output logic        mem_w_enable,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_w_data,
    input  logic [31:0] mem_r_data
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;
    typedef enum logic       {OWN_IF, OWN_LS}          owner_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e      state_q;
    owner_e      owner_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        mem_r_en_q;
    logic        mem_w_en_q;
    logic [3:0]  mem_be_q;
    logic        if_rsp_q;
    logic        ls_rsp_q;
    logic [3:0]  starve_q;
    logic [3:0]  starve_d;

    logic        grant_if;
    logic        grant_ls;
    logic        hs_if;
    logic        hs_ls;

    // The two low address bits are always dropped because accesses are
    // word aligned.
    logic        addr_lsb_unused;
    assign addr_lsb_unused = ^{if_req_addr[1:0], ls_req_addr[1:0]};

    // Arbitration is visible only in IDLE. Fetch takes a collision once it
    // has been passed over STARVE_MAX consecutive times.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state_q == S_IDLE) begin
            if (ls_req_valid && !(if_req_valid && starve_q == STARVE_LIM)) begin
                grant_ls = 1'b1;
            end else if (if_req_valid) begin
                grant_if = 1'b1;
            end
        end
    end

    // Gating with rst_n keeps ready low during reset, while IDLE is forced.
    assign if_req_ready = grant_if & rst_n;
    assign ls_req_ready = grant_ls & rst_n;
    assign hs_if        = if_req_valid & if_req_ready;
    assign hs_ls        = ls_req_valid & ls_req_ready;

    always_comb begin
        starve_d = starve_q;
        if (hs_if) begin
            starve_d = '0;
        end else if (hs_ls && if_req_valid && starve_q < STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // mem_addr and mem_w_data act as the latched request registers. They
    // change only when a handshake moves the FSM into ISSUE, so they hold
    // their values at all other times.
    // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            mem_be_q   <= '0;
            if_rsp_q   <= 1'b0;
            ls_rsp_q   <= 1'b0;
            starve_q   <= '0;
        end else begin
            starve_q   <= starve_d;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            mem_be_q   <= '0;
            if_rsp_q   <= 1'b0;
            ls_rsp_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (hs_ls) begin
                        owner_q    <= OWN_LS;
                        we_q       <= ls_req_we;
                        addr_q     <= {ls_req_addr[31:2], 2'b00};
                        mem_r_en_q <= ~ls_req_we;
                        mem_w_en_q <= ls_req_we;
                        if (ls_req_we) begin
                            wdata_q  <= ls_req_wdata;
                            mem_be_q <= ls_req_byte_en;
                        end
                        state_q    <= S_ISSUE;
                    end else if (hs_if) begin
                        owner_q    <= OWN_IF;
                        we_q       <= 1'b0;
                        addr_q     <= {if_req_addr[31:2], 2'b00};
                        mem_r_en_q <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A flush seen in ISSUE kills the fetch reply. A flush
                    // in RESP is masked on the output below.
                    if_rsp_q <= (owner_q == OWN_IF) && !if_flush;
                    ls_rsp_q <= (owner_q == OWN_LS);
                    state_q  <= S_RESP;
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_addr     = addr_q;
    assign mem_w_data   = wdata_q;
    assign mem_r_enable = mem_r_en_q;
    assign mem_w_enable = mem_w_en_q;
    assign mem_byte_en  = mem_be_q;

    // Read data comes straight from memory during RESP. Data outputs are 0
    // when no reply is being given.
    assign if_rsp_valid = if_rsp_q & ~if_flush;
    assign if_rsp_data  = if_rsp_valid ? mem_r_data : '0;
    assign ls_rsp_valid = ls_rsp_q;
    assign ls_rsp_data  = (ls_rsp_q && !we_q) ? mem_r_data : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive load/store grants allowed while a fetch request waits; range 1..15.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 if_req_valid  in  1  fetch requests a word read.
REQ-005 if_req_ready  out  1  arbiter accepts the fetch request this cycle.
REQ-006 if_req_addr  in  32  fetch byte address; bits [1:0] are ignored.
REQ-007 if_flush  in  1  cancels any in-flight fetch response (branch redirect).
REQ-008 if_rsp_valid  out  1  fetch read data valid for one cycle.
REQ-009 if_rsp_data  out  32  fetch read data.
REQ-010 ls_req_valid  in  1  load/store unit (LSU) requests an access.
REQ-011 ls_req_ready  out  1  arbiter accepts the LSU request this cycle.
REQ-012 ls_req_we  in  1  1 = store, 0 = load.
REQ-013 ls_req_addr  in  32  LSU byte address; bits [1:0] are ignored.
REQ-014 ls_req_byte_en  in  4  store byte lanes.
REQ-015 ls_req_wdata  in  32  store data.
REQ-016 ls_rsp_valid  out  1  LSU load data or store-completion valid for one cycle.
REQ-017 ls_rsp_data  out  32  load data; 0 for a store completion.
REQ-018 mem_addr  out  32  word-aligned memory address, bits [1:0] = 0.
REQ-019 mem_r_enable  out  1  memory read strobe.
REQ-020 mem_w_enable  out  1  memory write strobe.
REQ-021 mem_byte_en  out  4  write byte lanes.
REQ-022 mem_w_data  out  32  write data.
REQ-023 mem_r_data  in  32  read data, valid one cycle after the mem_r_enable cycle.

Function
REQ-024 The FSM SHALL have states IDLE, ISSUE and RESP, and SHALL hold one transaction at a time.
REQ-025 IDLE: ready SHALL be asserted only to the selected requester; the handshake (valid && ready) SHALL latch the address, write flag, byte enables, write data and owner, then go to ISSUE.
REQ-026 ISSUE (one cycle):
- Drive mem_addr from the latched address.
- Assert mem_r_enable for reads, or assert mem_w_enable with the latched byte enables and write data for stores.
- Go to RESP.
REQ-027 RESP (one cycle):
- Assert the owner's rsp_valid; rsp_data SHALL equal mem_r_data for reads and 0 for stores.
- Return to IDLE.
- Access latency is 2 cycles from handshake to response; throughput is one access per 3 cycles.
REQ-028 Outside ISSUE, mem_r_enable, mem_w_enable and mem_byte_en SHALL be 0; mem_addr and mem_w_data SHALL hold their last values.
REQ-029 Priority: the LSU SHALL win simultaneous requests unless starve_cnt == STARVE_MAX, in which case fetch SHALL win.
REQ-030 starve_cnt (4 bits):
- Increments on each LSU grant made while if_req_valid is high.
- Clears on each fetch grant.
- Holds otherwise and saturates at STARVE_MAX.
REQ-031 if_flush high in any cycle while a fetch owns ISSUE or RESP SHALL suppress that transaction's if_rsp_valid; the FSM timing SHALL be unchanged.
REQ-032 if_flush SHALL NOT affect LSU transactions or a fetch request being accepted in the same IDLE cycle.
REQ-033 Requesters SHALL hold valid and payload stable until accepted; the arbiter SHALL NOT sample payload except at the handshake.
REQ-034 Responses SHALL have no backpressure.

Reset
REQ-035 rst_n low SHALL immediately force:
- FSM to IDLE and starve_cnt to 0.
- All valid, ready and enable outputs, and mem_byte_en, to 0.
- mem_addr, mem_w_data, if_rsp_data and ls_rsp_data to 0.
REQ-036 Reset asserted mid-transaction SHALL abandon it with no response.
REQ-037 The first grant SHALL be possible in the first cycle after rst_n deasserts.

Verification
REQ-038 Fetch only, addr 0x00000104 -> ISSUE drives mem_addr 0x00000104 with mem_r_enable; mem_r_data 0xDEADBEEF -> if_rsp_valid with data 0xDEADBEEF 2 cycles after the handshake.
REQ-039 Simultaneous requests, LSU store addr 0x00000203, byte_en 0xC, wdata 0x12345678 -> LSU granted first; mem_addr 0x00000200 and mem_byte_en 0xC; ls_rsp_valid with data 0; fetch granted at the next IDLE.
REQ-040 Fetch and LSU held continuously valid, STARVE_MAX = 4 -> grant sequence LSU x4, fetch, LSU x4, fetch.
REQ-041 if_flush pulsed in the fetch ISSUE cycle -> if_rsp_valid stays 0; next grant in the following IDLE.
REQ-042 rst_n pulled low during LSU RESP -> ls_rsp_valid drops to 0 at once; after release an LSU request is accepted in the first cycle.
